// File: rtl/tone_detect.sv
// tone_detect: measures the period of a square-wave tone and decodes it to a one-hot 16-note key
//   clk      in   1   12 MHz system clock
//   rst      in   1   asynchronous reset, active-high
//   tone_in  in   1   asynchronous square wave, any duty cycle
//   key_out  out  16  one-hot decoded note, 0 = silence or no match
//   valid    out  1   key_out holds a qualified note
//   period   out  16  last measured period in clocks, 0 = none measured yet
// SCALE right-shifts the note table and the counter ceiling together so a
// simulation can run the same behaviour on shorter periods; 0 for the real part.
module tone_detect #(
  parameter int TOL_SHIFT = 6,
  parameter int MATCH_N = 3,
  parameter int SCALE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [15:0] key_out,
  output logic        valid,
  output logic [15:0] period
);
  localparam logic [15:0] CMAX = 16'hFFFF >> SCALE;
  localparam logic [2:0] MC = 3'(MATCH_N);
  localparam logic [255:0] NOM_TAB = {
    16'd10215, 16'd11478, 16'd12148, 16'd13636, 16'd15306, 16'd17180, 16'd18201, 16'd20432,
    16'd22931, 16'd24296, 16'd27273, 16'd30612, 16'd34364, 16'd36408, 16'd40858, 16'd45872
  };
  logic s1, s2, s3, rise, at_max, timeout, armed, meas_vld, cand_vld;
  logic [15:0] cnt, meas_r, cand, cand_r, last_cand;
  logic [2:0] match_cnt, nxt_cnt;
  assign rise = s2 & ~s3;
  assign at_max = cnt == CMAX;
  assign timeout = at_max & ~rise;
  // a repeat of the previous candidate extends the run (saturating), anything else restarts it
  assign nxt_cnt = (cand_r == last_cand) ? ((match_cnt == MC) ? MC : match_cnt + 3'd1) : 3'd1;
  for (genvar i = 0; i < 16; i++) begin : g_win
    localparam logic [16:0] NOM = 17'(NOM_TAB[i*16 +: 16] >> SCALE);
    localparam logic [16:0] LO = NOM - (NOM >> TOL_SHIFT);
    localparam logic [16:0] HI = NOM + (NOM >> TOL_SHIFT);
    assign cand[i] = ({1'b0, meas_r} >= LO) && ({1'b0, meas_r} <= HI);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      cnt <= '0;
      armed <= 1'b0;
      meas_r <= '0;
      meas_vld <= 1'b0;
      period <= '0;
    end else begin
      s1 <= tone_in;
      s2 <= s1;
      s3 <= s2;
      // a rise coinciding with the ceiling only re-arms: the interval overflowed
      meas_vld <= rise & armed & ~at_max;
      if (rise) begin
        cnt <= 16'd1;
        armed <= 1'b1;
        if (armed && !at_max) begin
          meas_r <= cnt;
          period <= cnt;
        end
      end else if (at_max) armed <= 1'b0;
      else cnt <= cnt + 16'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_r <= '0;
      cand_vld <= 1'b0;
      last_cand <= '0;
      match_cnt <= '0;
      key_out <= '0;
      valid <= 1'b0;
    end else begin
      cand_r <= cand;
      cand_vld <= meas_vld;
      if (timeout) begin
        match_cnt <= '0;
        key_out <= '0;
        valid <= 1'b0;
      end else if (cand_vld) begin
        if (cand_r == '0) begin
          match_cnt <= '0;
          key_out <= '0;
          valid <= 1'b0;
        end else begin
          match_cnt <= nxt_cnt;
          last_cand <= cand_r;
          if (nxt_cnt == MC) begin
            key_out <= cand_r;
            valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tone_detect.sv
// tb_tone_detect: randomized and directed tone periods checked against an interval-level model
module tb_tone_detect;
  localparam int SC = 5;
  localparam int TS = 6;
  localparam int MN = 3;
  localparam int CMAX = 65535 >> SC;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tone_in = 1'b0;
  logic [15:0] key_out, period;
  logic valid;
  tone_detect #(.TOL_SHIFT(TS), .MATCH_N(MN), .SCALE(SC)) dut (
    .clk(clk), .rst(rst), .tone_in(tone_in), .key_out(key_out), .valid(valid), .period(period)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int errors = 0;
  int last_k = 0;
  int nom_t [16] = '{45872, 40858, 36408, 34364, 30612, 27273, 24296, 22931,
                     20432, 18201, 17180, 15306, 13636, 12148, 11478, 10215};
  typedef struct {int c; logic [15:0] cand;} kev_t;
  int rq[$];
  kev_t kq[$];
  logic [15:0] e_key = '0, e_period = '0, last_c = '0;
  logic e_valid = 1'b0;
  bit m_armed = 0;
  int m_last = 0;
  int run = 0;
  function automatic logic [15:0] cand_of(input int p);
    logic [15:0] c;
    int n, t;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      n = nom_t[i] >> SC;
      t = n >> TS;
      if (p >= n - t && p <= n + t) c[i] = 1'b1;
    end
    return c;
  endfunction
  // a DUT rise r (cycle rise is high) shows period at r+1 and the qualify result at r+3
  task automatic model_rise(input int r);
    kev_t ev;
    if (m_armed && r - m_last < CMAX) begin
      e_period = 16'(r - m_last);
      ev.c = r + 3;
      ev.cand = cand_of(r - m_last);
      kq.push_back(ev);
    end
    m_armed = 1;
    m_last = r;
  endtask
  task automatic model_qual(input logic [15:0] cand);
    if (cand == '0) begin
      e_key = '0;
      e_valid = 1'b0;
      run = 0;
    end else begin
      if (cand == last_c && run > 0) run++;
      else begin
        run = 1;
        last_c = cand;
      end
      if (run >= MN) begin
        e_key = cand;
        e_valid = 1'b1;
      end
    end
  endtask
  always @(negedge clk) begin
    kev_t ev;
    if (rst) begin
      rq.delete();
      kq.delete();
      e_key = '0;
      e_valid = 1'b0;
      e_period = '0;
      last_c = '0;
      m_armed = 0;
      run = 0;
    end else begin
      while (rq.size() > 0 && rq[0] + 3 <= cyc) model_rise(rq.pop_front() + 2);
      while (kq.size() > 0 && kq[0].c <= cyc) begin
        ev = kq.pop_front();
        model_qual(ev.cand);
      end
      if (m_armed && cyc == m_last + CMAX + 1) begin
        m_armed = 0;
        e_key = '0;
        e_valid = 1'b0;
        run = 0;
      end
    end
    checks++;
    if ({key_out, valid, period} !== {e_key, e_valid, e_period}) begin
      errors++;
      $display("FAIL outputs cyc=%0d: key=%h valid=%b period=%0d, expected key=%h valid=%b period=%0d",
               cyc, key_out, valid, period, e_key, e_valid, e_period);
    end
  end
  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse(input int p, input int h);
    tone_in = 1'b1;
    last_k = cyc;
    rq.push_back(cyc);
    tick(h);
    tone_in = 1'b0;
    tick(p - h);
  endtask
  task automatic rand_seg();
    int sel, i, n, t, off, reps, p;
    sel = $urandom_range(0, 9);
    if (sel == 0) pulse(CMAX + int'($urandom_range(1, 200)), 100);
    else if (sel == 1) pulse(CMAX, 500);
    else begin
      i = $urandom_range(0, 15);
      n = nom_t[i] >> SC;
      t = n >> TS;
      off = int'($urandom_range(0, 2 * t + 4)) - (t + 2);
      reps = $urandom_range(1, 5);
      for (int j = 0; j < reps; j++) begin
        p = n + off + int'($urandom_range(0, 2)) - 1;
        pulse(p, $urandom_range(1, p - 1));
      end
    end
  endtask
  initial begin
    tick(5);
    rst = 1'b0;
    tick(10);
    lit("reset_key", key_out, 0);
    lit("reset_valid", valid, 0);
    lit("reset_period", period, 0);
    repeat (3) pulse(716, 358);
    lit("m1_after2_key", key_out, 0);
    lit("m1_after2_period", period, 716);
    pulse(727, 358);
    lit("m1_after3_key", key_out, 16'h0080);
    lit("m1_after3_valid", valid, 1);
    lit("model_m1_key", e_key, 16'h0080);
    pulse(728, 300);
    lit("win_hi_in_key", key_out, 16'h0080);
    lit("win_hi_in_period", period, 727);
    pulse(716, 358);
    lit("win_hi_out_key", key_out, 0);
    lit("win_hi_out_valid", valid, 0);
    repeat (2) pulse(716, 358);
    lit("requal_2_key", key_out, 0);
    pulse(705, 358);
    lit("requal_3_key", key_out, 16'h0080);
    pulse(704, 358);
    lit("win_lo_in_key", key_out, 16'h0080);
    pulse(716, 358);
    lit("win_lo_out_key", key_out, 0);
    lit("win_lo_out_period", period, 704);
    repeat (2) pulse(716, 358);
    pulse(638, 319);
    lit("m1_again_key", key_out, 16'h0080);
    pulse(638, 319);
    lit("m2_1_key", key_out, 16'h0080);
    pulse(638, 319);
    lit("m2_2_key", key_out, 16'h0080);
    pulse(1433, 700);
    lit("m2_3_key", key_out, 16'h0100);
    lit("model_m2_key", e_key, 16'h0100);
    repeat (2) pulse(1433, 700);
    pulse(319, 160);
    lit("l1_key", key_out, 16'h0001);
    repeat (2) pulse(319, 160);
    pulse(319, 160);
    lit("h2_key", key_out, 16'h8000);
    tick(last_k + CMAX + 2 - cyc);
    lit("timeout_before_key", key_out, 16'h8000);
    tick(1);
    lit("timeout_key", key_out, 0);
    lit("timeout_valid", valid, 0);
    lit("timeout_period_held", period, 319);
    tick(50);
    repeat (3) pulse(716, 358);
    lit("restart_2_key", key_out, 0);
    pulse(CMAX, 358);
    lit("restart_3_key", key_out, 16'h0080);
    pulse(CMAX - 1, 358);
    lit("ceil_rearm_key", key_out, 16'h0080);
    lit("ceil_rearm_period", period, 716);
    pulse(478, 48);
    lit("ceil_m1_key", key_out, 0);
    lit("ceil_m1_period", period, CMAX - 1);
    for (int i = 0; i < 3; i++) pulse(478, (i % 2) ? 48 : 430);
    lit("m5_duty_key", key_out, 16'h0800);
    pulse(937, 468);
    pulse(478, 48);
    lit("m5_gap_key", key_out, 0);
    repeat (2) pulse(478, 430);
    lit("m5_gap_2_key", key_out, 0);
    pulse(478, 48);
    lit("m5_requal_key", key_out, 16'h0800);
    tone_in = 1'b1;
    rq.push_back(cyc);
    tick(1);
    #2 rst = 1'b1;
    #1;
    lit("async_rst_key", key_out, 0);
    lit("async_rst_valid", valid, 0);
    lit("async_rst_period", period, 0);
    for (int i = 0; i < 20; i++) begin
      tone_in = ~tone_in;
      tick(1);
    end
    tone_in = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(5);
    lit("post_rst_key", key_out, 0);
    for (int s = 0; s < 15; s++) rand_seg();
    tick(CMAX + 20);
    lit("end_key", key_out, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
